axi_stream_strip_header: RTL and testbench

//  Inverse/downstream companion of the header-insert stage. Takes an AXI-Stream packet whose first beat

---
 rtl/axi_stream_strip_header.sv | 197 +++++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header
// Removes a per-packet H-byte header from the front of an AXI-Stream packet.
// The header goes out on a side port. The remaining payload is re-packed
// MSB-first on the output stream. A residual register carries the W-H bytes
// of each beat that spill into the next output beat.
module axi_stream_strip_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    valid_out,
   input  logic                    ready_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    valid_strip,
   output logic                    ready_strip,
   input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
   output logic                    valid_header,
   input  logic                    ready_header,
   output logic [DATA_WD-1:0]      data_header,
   output logic [DATA_BYTE_WD-1:0] keep_header
);

   typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_FLUSH} state_t;

   localparam logic [BYTE_CNT_WD:0] W_BYTES = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);
   localparam logic [BYTE_CNT_WD:0] ONE     = (BYTE_CNT_WD + 1)'(1);

   state_t                  state_q, state_d;
   logic [BYTE_CNT_WD:0]    h_q, h_d;
   logic [DATA_WD-1:0]      out_data_q, out_data_d;
   logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
   logic                    out_last_q, out_last_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
   logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;
   logic                    hdr_valid_q, hdr_valid_d;
   logic [DATA_WD-1:0]      resid_q, resid_d;
   logic [DATA_BYTE_WD-1:0] resid_keep_q, resid_keep_d;

   logic                    out_free, hdr_free, in_acc;
   logic [DATA_WD-1:0]      in_data_m, new_resid;
   logic [DATA_BYTE_WD-1:0] new_rkeep, hmask;
   logic [BYTE_CNT_WD:0]    rem_bytes;
   logic [BYTE_CNT_WD+3:0]  h_bits, rem_bits;

   // Expand a byte-enable vector into a bit mask over the data word.
   function automatic logic [DATA_WD-1:0] bytes_of(input logic [DATA_BYTE_WD-1:0] k);
      logic [DATA_WD-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) r[i*8 +: 8] = {8{k[i]}};
      return r;
   endfunction

   // Byte-enable mask selecting the top h bytes (all ones when h equals the bus width).
   function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [BYTE_CNT_WD:0] h);
      logic [DATA_BYTE_WD-1:0] ones;
      ones = '1;
      return ~(ones >> h);
   endfunction

   assign out_free  = !out_valid_q || ready_out;
   assign hdr_free  = !hdr_valid_q || ready_header;
   assign in_data_m = data_in & bytes_of(keep_in);
   assign h_bits    = {h_q, 3'b000};
   assign rem_bytes = W_BYTES - h_q;
   assign rem_bits  = {rem_bytes, 3'b000};
   // Shifting by the full width yields zero, so H = W leaves the residual empty.
   assign new_resid = in_data_m << h_bits;
   assign new_rkeep = keep_in << h_q;
   assign hmask     = top_mask(h_q);

   assign valid_out    = out_valid_q;
   assign data_out     = out_data_q;
   assign keep_out     = out_keep_q;
   assign last_out     = out_last_q;
   assign valid_header = hdr_valid_q;
   assign data_header  = hdr_data_q;
   assign keep_header  = hdr_keep_q;

   // Next-state, handshake and output-slot loading for the strip FSM.
   always_comb begin
      state_d      = state_q;
      h_d          = h_q;
      out_data_d   = out_data_q;
      out_keep_d   = out_keep_q;
      out_last_d   = out_last_q;
      out_valid_d  = out_valid_q && !ready_out;
      hdr_data_d   = hdr_data_q;
      hdr_keep_d   = hdr_keep_q;
      hdr_valid_d  = hdr_valid_q && !ready_header;
      resid_d      = resid_q;
      resid_keep_d = resid_keep_q;
      ready_in     = 1'b0;
      ready_strip  = 1'b0;
      in_acc       = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_strip = 1'b1;
            if (valid_strip) begin
               h_d     = {1'b0, byte_strip_cnt} + ONE;
               state_d = S_HEAD;
            end
         end
         S_HEAD: begin
            ready_in = hdr_free && out_free;
            in_acc   = valid_in && hdr_free && out_free;
            if (in_acc) begin
               hdr_data_d   = data_in & bytes_of(keep_in & hmask);
               hdr_keep_d   = keep_in & hmask;
               hdr_valid_d  = 1'b1;
               resid_d      = new_resid;
               resid_keep_d = new_rkeep;
               if (last_in) begin
                  if (new_rkeep != '0) begin
                     out_data_d  = new_resid;
                     out_keep_d  = new_rkeep;
                     out_last_d  = 1'b1;
                     out_valid_d = 1'b1;
                  end
                  state_d = S_IDLE;
               end else begin
                  state_d = S_BODY;
               end
            end
         end
         S_BODY: begin
            ready_in = out_free;
            in_acc   = valid_in && out_free;
            if (in_acc) begin
               out_data_d   = resid_q | (in_data_m >> rem_bits);
               out_keep_d   = resid_keep_q | (keep_in >> rem_bytes);
               out_valid_d  = 1'b1;
               out_last_d   = 1'b0;
               resid_d      = new_resid;
               resid_keep_d = new_rkeep;
               if (last_in) begin
                  if (new_rkeep != '0) begin
                     state_d = S_FLUSH;
                  end else begin
                     out_last_d = 1'b1;
                     state_d    = S_IDLE;
                  end
               end
            end
         end
         S_FLUSH: begin
            if (out_free) begin
               out_data_d  = resid_q;
               out_keep_d  = resid_keep_q;
               out_last_d  = 1'b1;
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output-slot registers; reset discards any partial packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         h_q          <= '0;
         out_data_q   <= '0;
         out_keep_q   <= '0;
         out_last_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         hdr_data_q   <= '0;
         hdr_keep_q   <= '0;
         hdr_valid_q  <= 1'b0;
         resid_q      <= '0;
         resid_keep_q <= '0;
      end else begin
         state_q      <= state_d;
         h_q          <= h_d;
         out_data_q   <= out_data_d;
         out_keep_q   <= out_keep_d;
         out_last_q   <= out_last_d;
         out_valid_q  <= out_valid_d;
         hdr_data_q   <= hdr_data_d;
         hdr_keep_q   <= hdr_keep_d;
         hdr_valid_q  <= hdr_valid_d;
         resid_q      <= resid_d;
         resid_keep_q <= resid_keep_d;
      end
   end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header with a 4-byte bus.
module tb_axi_stream_strip_header;

   localparam int DW = 32;
   localparam int BW = 4;
   localparam int CW = 2;

   typedef logic [36:0] beat_t;   // {data, keep, last}

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in, ready_in, last_in;
   logic [DW-1:0] data_in;
   logic [BW-1:0] keep_in;
   logic          valid_out, ready_out, last_out;
   logic [DW-1:0] data_out;
   logic [BW-1:0] keep_out;
   logic          valid_strip, ready_strip;
   logic [CW-1:0] byte_strip_cnt;
   logic          valid_header, ready_header;
   logic [DW-1:0] data_header;
   logic [BW-1:0] keep_header;

   int checks   = 0;
   int failures = 0;
   beat_t oq[$];
   beat_t hq[$];

   always #5 clk = ~clk;

   axi_stream_strip_header #(.DATA_WD(DW)) dut (
      .clk(clk), .rst(rst),
      .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
      .keep_in(keep_in), .last_in(last_in),
      .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
      .keep_out(keep_out), .last_out(last_out),
      .valid_strip(valid_strip), .ready_strip(ready_strip),
      .byte_strip_cnt(byte_strip_cnt),
      .valid_header(valid_header), .ready_header(ready_header),
      .data_header(data_header), .keep_header(keep_header)
   );

   // Record every completed transfer on both output ports.
   always @(negedge clk) begin
      if (!rst && valid_out && ready_out)       oq.push_back({data_out, keep_out, last_out});
      if (!rst && valid_header && ready_header) hq.push_back({data_header, keep_header, 1'b0});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic exp_out(input string tag, input int i, input logic [31:0] d,
                          input logic [3:0] k, input logic l);
      beat_t obs;
      obs = (i < oq.size()) ? oq[i] : 'x;
      chk(tag, 64'(obs), 64'({d, k, l}));
   endtask

   task automatic exp_hdr(input string tag, input int i, input logic [31:0] d, input logic [3:0] k);
      beat_t obs;
      obs = (i < hq.size()) ? hq[i] : 'x;
      chk(tag, 64'(obs), 64'({d, k, 1'b0}));
   endtask

   task automatic cfg(input logic [CW-1:0] cnt);
      int n;
      n = 0;
      byte_strip_cnt = cnt;
      valid_strip    = 1'b1;
      @(negedge clk);
      while (!ready_strip && n < 50) begin n++; @(negedge clk); end
      chk("cfg_ready", 64'(ready_strip), 64'd1);
      @(posedge clk); #1;
      valid_strip = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      n = 0;
      data_in  = d;
      keep_in  = k;
      last_in  = l;
      valid_in = 1'b1;
      @(negedge clk);
      while (!ready_in && n < 50) begin n++; @(negedge clk); end
      chk("beat_ready", 64'(ready_in), 64'd1);
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
      ready_out = 1'b1; valid_strip = 1'b0; byte_strip_cnt = '0; ready_header = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid_out", 64'(valid_out), 64'd0);
      chk("rst_valid_hdr", 64'(valid_header), 64'd0);
      chk("rst_ready_in", 64'(ready_in), 64'd0);
      chk("rst_ready_strip", 64'(ready_strip), 64'd1);
      chk("rst_out", 64'({data_out, keep_out, last_out}), 64'd0);
      chk("rst_hdr", 64'({data_header, keep_header}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: H=2, two beats, residual flushed
      cfg(2'd1);
      beat(32'hAABBCCDD, 4'hF, 1'b0);
      beat(32'h11223344, 4'hF, 1'b1);
      drain(5);
      chk("t1_nout", 64'(oq.size()), 64'd2);
      exp_out("t1_out0", 0, 32'hCCDD1122, 4'hF, 1'b0);
      exp_out("t1_out1", 1, 32'h33440000, 4'hC, 1'b1);
      chk("t1_nhdr", 64'(hq.size()), 64'd1);
      exp_hdr("t1_hdr", 0, 32'hAABB0000, 4'hC);
      oq.delete(); hq.delete();

      // 2: H=4, payload passes through unchanged
      cfg(2'd3);
      beat(32'h01020304, 4'hF, 1'b0);
      beat(32'h05060708, 4'hF, 1'b0);
      beat(32'h090A0000, 4'hC, 1'b1);
      drain(5);
      chk("t2_nout", 64'(oq.size()), 64'd2);
      exp_out("t2_out0", 0, 32'h05060708, 4'hF, 1'b0);
      exp_out("t2_out1", 1, 32'h090A0000, 4'hC, 1'b1);
      exp_hdr("t2_hdr", 0, 32'h01020304, 4'hF);
      oq.delete(); hq.delete();

      // 3: H=1, single partial beat
      cfg(2'd0);
      beat(32'hAABBCCDD, 4'hE, 1'b1);
      drain(4);
      chk("t3_nout", 64'(oq.size()), 64'd1);
      exp_out("t3_out0", 0, 32'hBBCC0000, 4'hC, 1'b1);
      exp_hdr("t3_hdr", 0, 32'hAA000000, 4'h8);
      chk("t3_idle", 64'(ready_strip), 64'd1);
      oq.delete(); hq.delete();

      // 4: H=2, short last beat fits entirely, no flush beat
      cfg(2'd1);
      beat(32'hAABBCCDD, 4'hF, 1'b0);
      beat(32'h11000000, 4'h8, 1'b1);
      drain(5);
      chk("t4_nout", 64'(oq.size()), 64'd1);
      exp_out("t4_out0", 0, 32'hCCDD1100, 4'hE, 1'b1);
      oq.delete(); hq.delete();

      // 5: back-pressure on both output ports
      ready_header = 1'b0;
      cfg(2'd1);
      beat(32'hAABBCCDD, 4'hF, 1'b0);
      beat(32'h11223344, 4'hF, 1'b0);
      ready_out = 1'b0;
      data_in = 32'h55667788; keep_in = 4'hF; last_in = 1'b1; valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", 64'(valid_out), 64'd1);
         chk("t5_hold_data", 64'({data_out, keep_out, last_out}), 64'({32'hCCDD1122, 4'hF, 1'b0}));
         chk("t5_stall_in", 64'(ready_in), 64'd0);
      end
      @(posedge clk); #1;
      ready_out = 1'b1;
      beat(32'h55667788, 4'hF, 1'b1);
      drain(3);
      chk("t5_hdr_held_v", 64'(valid_header), 64'd1);
      chk("t5_hdr_held_d", 64'({data_header, keep_header}), 64'({32'hAABB0000, 4'hC}));
      cfg(2'd0);
      data_in = 32'h01020304; keep_in = 4'hF; last_in = 1'b1; valid_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t5_head_stall", 64'(ready_in), 64'd0);
         chk("t5_head_hdr", 64'(data_header), 64'h00000000AABB0000);
      end
      @(posedge clk); #1;
      ready_header = 1'b1;
      beat(32'h01020304, 4'hF, 1'b1);
      drain(5);
      chk("t5_nout", 64'(oq.size()), 64'd4);
      exp_out("t5_out0", 0, 32'hCCDD1122, 4'hF, 1'b0);
      exp_out("t5_out1", 1, 32'h33445566, 4'hF, 1'b0);
      exp_out("t5_out2", 2, 32'h77880000, 4'hC, 1'b1);
      exp_out("t5_out3", 3, 32'h02030400, 4'hE, 1'b1);
      chk("t5_nhdr", 64'(hq.size()), 64'd2);
      exp_hdr("t5_hdr0", 0, 32'hAABB0000, 4'hC);
      exp_hdr("t5_hdr1", 1, 32'h01000000, 4'h8);
      oq.delete(); hq.delete();

      // 6: reset in the middle of a packet, then a clean packet
      cfg(2'd1);
      beat(32'hAABBCCDD, 4'hF, 1'b0);
      ready_out = 1'b0;
      beat(32'h11223344, 4'hF, 1'b0);
      data_in = 32'h55667788; keep_in = 4'hF; last_in = 1'b1; valid_in = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; valid_in = 1'b0;
      @(negedge clk);
      chk("t6_valid_out", 64'(valid_out), 64'd0);
      chk("t6_valid_hdr", 64'(valid_header), 64'd0);
      chk("t6_ready_strip", 64'(ready_strip), 64'd1);
      chk("t6_ready_in", 64'(ready_in), 64'd0);
      chk("t6_out_clr", 64'({data_out, keep_out, last_out}), 64'd0);
      chk("t6_nout", 64'(oq.size()), 64'd0);
      @(posedge clk); #1;
      oq.delete(); hq.delete();
      ready_out = 1'b1;
      cfg(2'd1);
      beat(32'hAABBCCDD, 4'hF, 1'b0);
      beat(32'h11223344, 4'hF, 1'b1);
      drain(5);
      chk("t6_nout2", 64'(oq.size()), 64'd2);
      exp_out("t6_out0", 0, 32'hCCDD1122, 4'hF, 1'b0);
      exp_out("t6_out1", 1, 32'h33440000, 4'hC, 1'b1);
      exp_hdr("t6_hdr", 0, 32'hAABB0000, 4'hC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
